// File: rtl/vec_player_capture.sv
// Stimulus player / response capture engine for combinational DUTs: stimulus RAM, run FSM, response RAM.
// Optional MISR signature over captured responses when VEC_PLAYER_MISR_EN is defined.
module vec_player_capture #(
  parameter int                   VEC_WIDTH = 36,
  parameter int                   OUT_WIDTH = 7,
  parameter int                   DEPTH     = 256,
  parameter int                   AW        = 8,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY = 7'h41
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_we,
  input  logic [AW-1:0]        load_addr,
  input  logic [VEC_WIDTH-1:0] load_data,
  input  logic [AW:0]          vec_len,
  input  logic [7:0]           loop_cnt,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [VEC_WIDTH-1:0] vec,
  output logic                 vec_valid,
  input  logic [OUT_WIDTH-1:0] dut_out,
  input  logic [AW-1:0]        rd_addr,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic [31:0]          vec_cnt,
  output logic [OUT_WIDTH-1:0] sig
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 vec_valid_q, vec_valid_d;
  logic [VEC_WIDTH-1:0] vec_q, vec_d;
  logic [31:0]          vec_cnt_q, vec_cnt_d;
  logic [AW-1:0]        idx_q, idx_d, cap_idx_q, cap_idx_d;
  logic [AW:0]          len_q, len_d;
  logic [7:0]           pass_q, pass_d, passes_q, passes_d;
  logic [OUT_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [VEC_WIDTH-1:0] stim_mem [DEPTH];
  logic [OUT_WIDTH-1:0] resp_mem [DEPTH];

  logic accept, len_ok, last_idx, last_pass, stim_we, resp_we;

  assign accept    = (state_q == S_IDLE) && start;
  assign len_ok    = (vec_len != '0) && (vec_len <= (AW+1)'(DEPTH));
  assign last_idx  = ({1'b0, idx_q} == len_q - (AW+1)'(1));
  assign last_pass = (pass_q == passes_q - 8'd1);
  assign stim_we   = load_we && !busy_q;
  // A vector presented last cycle is captured at this edge, whatever the state is now.
  assign resp_we   = vec_valid_q && !rst;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    vec_valid_d = vec_valid_q;
    vec_d       = vec_q;
    vec_cnt_d   = vec_cnt_q;
    idx_d       = idx_q;
    cap_idx_d   = cap_idx_q;
    len_d       = len_q;
    pass_d      = pass_q;
    passes_d    = passes_q;
    rd_data_d   = resp_mem[rd_addr];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          vec_cnt_d = '0;
          if (len_ok) begin
            state_d  = S_RUN;
            err_d    = 1'b0;
            idx_d    = '0;
            pass_d   = '0;
            len_d    = vec_len;
            passes_d = (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d     = S_DRAIN;
          vec_valid_d = 1'b0;
        end else begin
          vec_d       = stim_mem[idx_q];
          vec_valid_d = 1'b1;
          cap_idx_d   = idx_q;
          vec_cnt_d   = (vec_cnt_q == '1) ? vec_cnt_q : vec_cnt_q + 32'd1;
          if (last_idx) begin
            idx_d = '0;
            if (last_pass) state_d = S_DRAIN;
            else           pass_d  = pass_q + 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        vec_valid_d = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_q       <= '0;
      vec_cnt_q   <= '0;
      idx_q       <= '0;
      cap_idx_q   <= '0;
      len_q       <= '0;
      pass_q      <= '0;
      passes_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      vec_valid_q <= vec_valid_d;
      vec_q       <= vec_d;
      vec_cnt_q   <= vec_cnt_d;
      idx_q       <= idx_d;
      cap_idx_q   <= cap_idx_d;
      len_q       <= len_d;
      pass_q      <= pass_d;
      passes_q    <= passes_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // NOTE: RAM arrays have no reset so they map onto plain memory; contents survive rst.
  always_ff @(posedge clk) begin
    if (stim_we) stim_mem[load_addr] <= load_data;
    if (resp_we) resp_mem[cap_idx_q] <= dut_out;
  end

`ifdef VEC_PLAYER_MISR_EN
  logic [OUT_WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (accept)       sig_d = '0;
    else if (resp_we) sig_d = {sig_q[OUT_WIDTH-2:0], 1'b0}
                              ^ (sig_q[OUT_WIDTH-1] ? MISR_POLY : '0) ^ dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
`else
  // Constant zero; the AND keeps MISR_POLY referenced in this build.
  assign sig = MISR_POLY & '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign vec_cnt   = vec_cnt_q;
  assign rd_data   = rd_data_q;

endmodule
